// File: rtl/md_unit_if.sv
// Handshake/bus bundle between the control path and the multiply/divide unit.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Wr_Hi;
  logic             Wr_Lo;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  // Requester side: issues operations and MTHI/MTLO writes, observes results.
  modport master (
    output Start, Op, A, B, Wr_Hi, Wr_Lo,
    input  Busy, Done, Hi, Lo
  );

  // Unit side.
  modport slave (
    input  Start, Op, A, B, Wr_Hi, Wr_Lo,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/md_unit.sv
// Iterative 32-step multiply/divide unit with HI/LO result registers.
// Operands are reduced to magnitudes on entry, iterated unsigned, and
// sign-corrected in a final FIX cycle before HI/LO are written.
module md_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic     Clk,
  input  logic     Clr,
  md_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam int unsigned ACC_W = 2 * WIDTH;

  state_t             r_state;
  logic               r_is_div;   // Op[1] of the running operation
  logic [WIDTH-1:0]   r_a_mag;
  logic [WIDTH-1:0]   r_b_mag;
  logic [WIDTH-1:0]   r_a_raw;    // original dividend, returned on divide by zero
  logic               r_div0;
  logic               r_neg_p;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;      // multiply accumulator {high, multiplier/low}
  logic [WIDTH-1:0]   r_rem;      // divide partial remainder
  logic [WIDTH-1:0]   r_quo;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;

  // Operand magnitudes and result signs, evaluated on the request cycle.
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;

  assign w_signed = bus.Op[0];
  assign w_a_neg  = w_signed & bus.A[WIDTH-1];
  assign w_b_neg  = w_signed & bus.B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (WIDTH'(0) - bus.A) : bus.A;
  assign w_b_mag  = w_b_neg ? (WIDTH'(0) - bus.B) : bus.B;

  // Shift-add multiply step: conditionally add multiplicand to the high half, shift right.
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [ACC_W-1:0]   w_acc_next;

  assign w_addend   = r_acc[0] ? {1'b0, r_a_mag} : (WIDTH + 1)'(0);
  assign w_mul_sum  = {1'b0, r_acc[ACC_W-1:WIDTH]} + w_addend;
  assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: the WIDTH+1-bit shifted partial remainder is trial-subtracted.
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_sub;
  logic [WIDTH-1:0]   w_rem_next;

  assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b_mag});
  assign w_div_sub   = WIDTH'(w_div_shift - {1'b0, r_b_mag});
  assign w_rem_next  = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];

  // Sign-corrected results consumed in FIX.
  logic [ACC_W-1:0]   w_prod;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_prod    = r_neg_p ? (ACC_W'(0) - r_acc) : r_acc;
  assign w_quo_fix = r_neg_q ? (WIDTH'(0) - r_quo) : r_quo;
  assign w_rem_fix = r_neg_r ? (WIDTH'(0) - r_rem) : r_rem;

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state  <= S_IDLE;
      r_is_div <= 1'b0;
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_a_raw  <= '0;
      r_div0   <= 1'b0;
      r_neg_p  <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            // Start takes priority over MTHI/MTLO in the same cycle.
            r_is_div <= bus.Op[1];
            r_a_mag  <= w_a_mag;
            r_b_mag  <= w_b_mag;
            r_a_raw  <= bus.A;
            r_div0   <= (bus.B == WIDTH'(0));
            r_neg_p  <= w_a_neg ^ w_b_neg;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_cnt    <= '0;
            r_acc    <= {WIDTH'(0), w_b_mag};
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            if (bus.Wr_Hi) r_hi <= bus.A;
            if (bus.Wr_Lo) r_lo <= bus.A;
          end
        end

        S_RUN: begin
          if (r_is_div) begin
            r_rem <= w_rem_next;
            r_quo <= {r_quo[WIDTH-2:0], w_div_ge};
          end else begin
            r_acc <= w_acc_next;
          end
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod[ACC_W-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (r_div0) begin
            r_hi <= r_a_raw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Busy = r_busy;
  assign bus.Done = r_done;
  assign bus.Hi   = r_hi;
  assign bus.Lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: vector table plus multi-cycle corner sequences.
module tb_md_unit;

  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(WIDTH)) bus ();

  md_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .Clk (clk),
    .Clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    bus.Start = 1'b0;
    bus.Wr_Hi = 1'b0;
    bus.Wr_Lo = 1'b0;
    bus.Op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;
  endtask

  // Issue a request at the next edge (E0); operands are scrambled afterwards.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    bus.Wr_Hi = 1'b0;
    bus.Wr_Lo = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    check({name, " busy after E0"}, 64'(bus.Busy), 64'd1);
    check({name, " hi held at E0"}, 64'(bus.Hi), 64'(m_hi));
  endtask

  // Wait for Done (bounded), checking latency, hold during RUN and results.
  task automatic wait_done(input string name, input int already,
                           input logic [31:0] eh, input logic [31:0] el);
    int lat = 0;
    logic held = 1'b1;
    for (int k = already + 1; k <= 40; k++) begin
      tick();
      if (bus.Done) begin
        lat = k;
        break;
      end
      if (!bus.Busy || bus.Hi !== m_hi || bus.Lo !== m_lo) held = 1'b0;
    end
    check({name, " done latency"}, 64'(lat), 64'd33);
    check({name, " busy/hi/lo held in run"}, 64'(held), 64'd1);
    check({name, " busy low at done"}, 64'(bus.Busy), 64'd0);
    check({name, " hi"}, 64'(bus.Hi), 64'(eh));
    check({name, " lo"}, 64'(bus.Lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic seen_done;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6]  = '{2'b00, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[7]  = '{2'b10, 32'd1000,      32'd7,         32'd6,         32'd142};
    vecs[8]  = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[10] = '{2'b01, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vecs[11] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[12] = '{2'b11, 32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2};
    vecs[13] = '{2'b11, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2};

    // Reset.
    drive_idle();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("reset busy", 64'(bus.Busy), 64'd0);
    check("reset done", 64'(bus.Done), 64'd0);
    check("reset hi",   64'(bus.Hi),   64'd0);
    check("reset lo",   64'(bus.Lo),   64'd0);

    // DIV -7/2, then a DIVU by zero requested in the Done cycle.
    start_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    wait_done("div_m7_2", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    start_op(2'b10, 32'd100, 32'd0, "divu_in_done");
    check("done drops after restart", 64'(bus.Done), 64'd0);
    wait_done("divu_in_done", 0, 32'h0000_0064, 32'hFFFF_FFFF);
    tick();
    check("divu_in_done pulse width", 64'(bus.Done), 64'd0);

    // MTHI / MTLO in idle, then Start with Wr_Hi, and ignored requests mid-run.
    bus.A = 32'h1234_5678;
    bus.Wr_Hi = 1'b1;
    tick();
    bus.Wr_Hi = 1'b0;
    check("mthi hi",      64'(bus.Hi),   64'h1234_5678);
    check("mthi no done", 64'(bus.Done), 64'd0);
    check("mthi lo kept", 64'(bus.Lo),   64'(m_lo));
    m_hi = 32'h1234_5678;
    bus.A = 32'hCAFE_F00D;
    bus.Wr_Lo = 1'b1;
    tick();
    bus.Wr_Lo = 1'b0;
    check("mtlo lo",      64'(bus.Lo), 64'hCAFE_F00D);
    check("mtlo hi kept", 64'(bus.Hi), 64'(m_hi));
    m_lo = 32'hCAFE_F00D;
    bus.Wr_Hi = 1'b1;
    start_op(2'b00, 32'd3, 32'd5, "multu_3_5");
    repeat (4) tick();
    bus.Start = 1'b1;
    bus.Wr_Lo = 1'b1;
    bus.Op    = 2'b10;
    bus.A     = 32'd99;
    bus.B     = 32'd1;
    tick();
    bus.Start = 1'b0;
    bus.Wr_Lo = 1'b0;
    wait_done("multu_3_5", 5, 32'd0, 32'd15);
    tick();
    check("multu_3_5 no restart", 64'(bus.Busy), 64'd0);

    // Abort mid-run with Clr.
    start_op(2'b10, 32'd1000, 32'd7, "abort");
    repeat (9) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("abort busy", 64'(bus.Busy), 64'd0);
    check("abort hi",   64'(bus.Hi),   64'd0);
    check("abort lo",   64'(bus.Lo),   64'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.Done) seen_done = 1'b1;
      tick();
    end
    check("abort never done", 64'(seen_done), 64'd0);

    // Table of operations.
    drive_idle();
    for (int i = 0; i < NVEC; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, nm);
      wait_done(nm, 0, vecs[i].hi, vecs[i].lo);
      tick();
      check({nm, " done pulse width"}, 64'(bus.Done), 64'd0);
      check({nm, " idle after"},       64'(bus.Busy), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
